// File: rtl/switch_bounce_gen_if.sv
// Bundle between a stimulus source and the contact-bounce emulator.
//   master : drives en, level_in, seed_load, seed; observes sw_out, busy, done
//   slave  : the emulator itself (switch_bounce_gen)
// Signals:
//   en        1 = emulate bounce, 0 = bypass (sw_out follows level_in)
//   level_in  clean target switch level
//   seed_load one-cycle strobe loading seed into the LFSR
//   seed      16-bit LFSR seed (0 selects the built-in seed)
//   sw_out    emulated bouncy switch output
//   busy      transition in progress
//   done      one-cycle pulse when a transition completes
interface switch_bounce_gen_if;
  logic        en;
  logic        level_in;
  logic        seed_load;
  logic [15:0] seed;
  logic        sw_out;
  logic        busy;
  logic        done;

  modport master (
    output en, level_in, seed_load, seed,
    input  sw_out, busy, done
  );

  modport slave (
    input  en, level_in, seed_load, seed,
    output sw_out, busy, done
  );
endinterface

// File: rtl/switch_bounce_gen.sv
// Contact-bounce emulator. Given a clean target level it produces a
// switch-like output that chatters N times (N pairs of opposite-level
// segments) before settling on the target for HOLD cycles. Bounce count and
// segment lengths come from a 16-bit Fibonacci LFSR, so a given seed always
// reproduces the same waveform.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  switch_bounce_gen_if.slave (en, level_in, seed_load, seed in;
//        sw_out, busy, done out)
module switch_bounce_gen #(
  parameter int unsigned BOUNCE_MAX = 5,
  parameter int unsigned SEG_W      = 4,
  parameter int unsigned HOLD       = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic                clk,
  input logic                rst,
  switch_bounce_gen_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(HOLD + 1);
  localparam logic [SEG_W:0]    SEG_ONE  = (SEG_W + 1)'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              committed_q, committed_d;
  logic              target_q, target_d;
  logic              phase_q, phase_d;      // 1 = target phase, 0 = return phase
  logic              sw_q, sw_d;
  logic              done_q, done_d;
  logic [SEG_W:0]    seg_q, seg_d;          // cycles left in current segment
  logic [3:0]        pair_q, pair_d;        // bounce pairs still to emit
  logic [HOLD_W-1:0] hold_q, hold_d;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [SEG_W:0] seg_len(input logic [SEG_W-1:0] v);
    return {1'b0, v} + SEG_ONE;
  endfunction

  // Bounce pair count: never zero, never above BOUNCE_MAX
  function automatic logic [3:0] pair_num(input logic [3:0] v);
    logic [3:0] n;
    n = v;
    if (n == 4'd0) n = 4'd1;
    if (n > 4'(BOUNCE_MAX)) n = 4'(BOUNCE_MAX);
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    committed_d = committed_q;
    target_d    = target_q;
    phase_d     = phase_q;
    sw_d        = sw_q;
    seg_d       = seg_q;
    pair_d      = pair_q;
    hold_d      = hold_q;
    done_d      = 1'b0;

    lfsr_d = bus.en ? lfsr_step(lfsr_q) : lfsr_q;
    if (bus.seed_load) lfsr_d = (bus.seed == 16'h0) ? LFSR_SEED : bus.seed;

    if (!bus.en) begin
      state_d     = IDLE;
      sw_d        = bus.level_in;
      committed_d = bus.level_in;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.level_in != committed_q) begin
            target_d = bus.level_in;
            pair_d   = pair_num(lfsr_q[7:4]);
            seg_d    = seg_len(lfsr_q[SEG_W-1:0]);
            phase_d  = 1'b1;
            sw_d     = bus.level_in;
            state_d  = BOUNCE;
          end
        end
        BOUNCE: begin
          if (bus.level_in == committed_q) begin
            // target withdrawn: snap back to the settled level
            state_d = IDLE;
            sw_d    = committed_q;
          end else if (seg_q == SEG_ONE) begin
            if (phase_q) begin
              phase_d = 1'b0;
              sw_d    = committed_q;
              seg_d   = seg_len(lfsr_q[SEG_W-1:0]);
            end else if (pair_q == 4'd1) begin
              // last return phase over: final edge to target
              state_d = SETTLE;
              sw_d    = target_q;
              pair_d  = 4'd0;
              hold_d  = HOLD_W'(HOLD);
            end else begin
              pair_d  = pair_q - 4'd1;
              phase_d = 1'b1;
              sw_d    = target_q;
              seg_d   = seg_len(lfsr_q[SEG_W-1:0]);
            end
          end else begin
            seg_d = seg_q - SEG_ONE;
          end
        end
        SETTLE: begin
          if (hold_q == HOLD_ONE) begin
            state_d     = IDLE;
            committed_d = target_q;
            done_d      = 1'b1;
          end else begin
            hold_d = hold_q - HOLD_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      committed_q <= 1'b0;
      target_q    <= 1'b0;
      phase_q     <= 1'b0;
      sw_q        <= 1'b0;
      done_q      <= 1'b0;
      seg_q       <= '0;
      pair_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      committed_q <= committed_d;
      target_q    <= target_d;
      phase_q     <= phase_d;
      sw_q        <= sw_d;
      done_q      <= done_d;
      seg_q       <= seg_d;
      pair_q      <= pair_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.sw_out = sw_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;

endmodule
